// File: rtl/inst_fetch.sv
// inst_fetch: program counter and fetch sequencer that drives the instruction
// ROM address. It arms on Start, runs on Start's falling level, follows
// absolute and PC-relative branches, honours stall and halt, and counts the
// instructions retired in the current run.
module inst_fetch #(
  parameter int A_WIDTH   = 11,
  parameter int OFF_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 BranchAbs,
  input  logic                 BranchRel,
  input  logic                 Taken,
  input  logic [A_WIDTH-1:0]   Target,
  input  logic [OFF_WIDTH-1:0] Offset,
  output logic [A_WIDTH-1:0]   InstAddress,
  output logic                 Running,
  output logic                 Done,
  output logic [CNT_WIDTH-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   pc_q, pc_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [A_WIDTH-1:0]   offset_ext;
  logic [A_WIDTH-1:0]   pc_rel;
  logic [A_WIDTH-1:0]   pc_inc;
  logic [CNT_WIDTH-1:0] cnt_sat_inc;

  // Sign-extend the relative offset and precompute the candidate next PCs;
  // the A_WIDTH-bit sums wrap naturally modulo the ROM depth.
  always_comb begin
    offset_ext  = {{(A_WIDTH-OFF_WIDTH){Offset[OFF_WIDTH-1]}}, Offset};
    pc_rel      = pc_q + offset_ext;
    pc_inc      = pc_q + {{(A_WIDTH-1){1'b0}}, 1'b1};
    cnt_sat_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q
                                               : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // Next-state, next-PC and next-output decision; outputs are computed one
  // cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    running_d = running_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        pc_d      = '0;
        running_d = 1'b0;
        done_d    = 1'b0;
        if (Start) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        pc_d   = '0;
        cnt_d  = '0;
        done_d = 1'b0;
        if (!Start) begin
          state_d   = RUN;
          running_d = 1'b1;
        end
      end
      RUN: begin
        if (Start) begin
          state_d   = ARMED;
          pc_d      = '0;
          cnt_d     = '0;
          running_d = 1'b0;
        end else begin
          if (!Stall || Halt) begin
            cnt_d = cnt_sat_inc;
          end
          if (Halt) begin
            state_d   = DONE;
            running_d = 1'b0;
            done_d    = 1'b1;
          end else if (Stall) begin
            pc_d = pc_q;
          end else if (BranchAbs && Taken) begin
            pc_d = Target;
          end else if (BranchRel && Taken) begin
            pc_d = pc_rel;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = ARMED;
          pc_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        pc_d      = '0;
        running_d = 1'b0;
        done_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign Running     = running_q;
  assign Done        = done_q;
  assign InstCount   = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table of directed vectors, a straight-line halt sequence and a
// randomized phase compared against a behavioural model of the fetch sequencer.
module tb_inst_fetch;

  localparam int AW = 11;
  localparam int OW = 8;
  localparam int CW = 16;
  localparam int DEPTH = 2048;
  localparam int CNT_MAX = 65535;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    bit          rst;
    bit          start;
    bit          stall;
    bit          halt;
    bit          babs;
    bit          brel;
    bit          taken;
    logic [10:0] target;
    logic [7:0]  offset;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    int    pc;
    int    run;
    int    done;
    int    cnt;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stall;
  logic          halt;
  logic          branch_abs;
  logic          branch_rel;
  logic          taken;
  logic [AW-1:0] target;
  logic [OW-1:0] offset;
  logic [AW-1:0] inst_address;
  logic          running;
  logic          done;
  logic [CW-1:0] inst_count;

  int checks = 0;
  int errors = 0;

  int m_state = M_IDLE;
  int m_pc    = 0;
  int m_cnt   = 0;

  vec_t vecs[$];

  inst_fetch #(.A_WIDTH(AW), .OFF_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .Clk(clk),
    .Reset(reset),
    .Start(start),
    .Stall(stall),
    .Halt(halt),
    .BranchAbs(branch_abs),
    .BranchRel(branch_rel),
    .Taken(taken),
    .Target(target),
    .Offset(offset),
    .InstAddress(inst_address),
    .Running(running),
    .Done(done),
    .InstCount(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkIn(bit rst, bit st, bit sl, bit hl, bit ba, bit br, bit tk,
                               int tgt, int off);
    in_t r;
    r.rst = rst; r.start = st; r.stall = sl; r.halt = hl;
    r.babs = ba; r.brel = br; r.taken = tk;
    r.target = tgt[10:0];
    r.offset = off[7:0];
    return r;
  endfunction

  function automatic void addVec(string nm, in_t i, int pc, int run, int dn, int cnt);
    vec_t v;
    v.name = nm; v.in = i; v.pc = pc; v.run = run; v.done = dn; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  // Behavioural model: one clock of the fetch sequencer, straight from the rules.
  function automatic void modelStep(in_t i);
    int so;
    if (i.rst) begin
      m_state = M_IDLE; m_pc = 0; m_cnt = 0;
      return;
    end
    case (m_state)
      M_IDLE:  if (i.start) begin m_state = M_ARMED; m_pc = 0; m_cnt = 0; end
      M_ARMED: begin
        m_pc = 0; m_cnt = 0;
        if (!i.start) m_state = M_RUN;
      end
      M_RUN: begin
        if (i.start) begin
          m_state = M_ARMED; m_pc = 0; m_cnt = 0;
        end else begin
          if (!i.stall || i.halt) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
          if (i.halt) m_state = M_DONE;
          else if (i.stall) m_pc = m_pc;
          else if (i.babs && i.taken) m_pc = int'(i.target);
          else if (i.brel && i.taken) begin
            so = int'($signed(i.offset));
            m_pc = (((m_pc + so) % DEPTH) + DEPTH) % DEPTH;
          end else m_pc = (m_pc + 1) % DEPTH;
        end
      end
      default: if (i.start) begin m_state = M_ARMED; m_pc = 0; m_cnt = 0; end
    endcase
  endfunction

  task automatic checkVal(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkOutput(string nm, int pc, int run, int dn, int cnt);
    checkVal({nm, ".InstAddress"}, int'(inst_address), pc);
    checkVal({nm, ".Running"}, int'(running), run);
    checkVal({nm, ".Done"}, int'(done), dn);
    checkVal({nm, ".InstCount"}, int'(inst_count), cnt);
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, settle.
  task automatic applyStimulus(in_t i);
    @(negedge clk);
    reset = i.rst; start = i.start; stall = i.stall; halt = i.halt;
    branch_abs = i.babs; branch_rel = i.brel; taken = i.taken;
    target = i.target; offset = i.offset;
    @(posedge clk);
    modelStep(i);
    #1;
  endtask

  task automatic checkModel(string nm);
    checkOutput(nm, m_pc, (m_state == M_RUN) ? 1 : 0, (m_state == M_DONE) ? 1 : 0, m_cnt);
  endtask

  initial begin
    in_t idle;
    in_t r;
    idle = mkIn(0,0,0,0,0,0,0,0,0);
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_abs = 1'b0; branch_rel = 1'b0; taken = 1'b0;
    target = '0; offset = '0;

    //                       rst st sl hl ba br tk  tgt  off      pc  run dn cnt
    addVec("reset",     mkIn(1, 0, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("rst_start", mkIn(1, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("idle",      idle,                                      0, 0, 0, 0);
    addVec("arm0",      mkIn(0, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("arm1",      mkIn(0, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("arm2",      mkIn(0, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("run_pc0",   idle,                                      0, 1, 0, 0);
    addVec("run_pc1",   idle,                                      1, 1, 0, 1);
    addVec("run_pc2",   idle,                                      2, 1, 0, 2);
    addVec("run_pc3",   idle,                                      3, 1, 0, 3);
    addVec("run_pc4",   idle,                                      4, 1, 0, 4);
    addVec("run_pc5",   idle,                                      5, 1, 0, 5);
    addVec("abs_taken", mkIn(0, 0, 0, 0, 1, 0, 1, 100,    0),    100, 1, 0, 6);
    addVec("abs_to5",   mkIn(0, 0, 0, 0, 1, 0, 1,   5,    0),      5, 1, 0, 7);
    addVec("abs_ntkn",  mkIn(0, 0, 0, 0, 1, 0, 0, 100,    0),      6, 1, 0, 8);
    addVec("abs_wins",  mkIn(0, 0, 0, 0, 1, 1, 1,  10, 'h7F),     10, 1, 0, 9);
    addVec("rel_neg",   mkIn(0, 0, 0, 0, 0, 1, 1,   0, 'hFC),      6, 1, 0, 10);
    addVec("rel_ntkn",  mkIn(0, 0, 0, 0, 0, 1, 0,   0, 'hFC),      7, 1, 0, 11);
    addVec("stall0",    mkIn(0, 0, 1, 0, 0, 0, 0,   0,    0),      7, 1, 0, 11);
    addVec("stall1",    mkIn(0, 0, 1, 0, 0, 0, 0,   0,    0),      7, 1, 0, 11);
    addVec("stall_br",  mkIn(0, 0, 1, 0, 1, 0, 1,  50,    0),      7, 1, 0, 11);
    addVec("abs_2046",  mkIn(0, 0, 0, 0, 1, 0, 1, 2046,   0),   2046, 1, 0, 12);
    addVec("rel_wrap",  mkIn(0, 0, 0, 0, 0, 1, 1,   0,    3),      1, 1, 0, 13);
    addVec("abs_2047",  mkIn(0, 0, 0, 0, 1, 0, 1, 2047,   0),   2047, 1, 0, 14);
    addVec("inc_wrap",  idle,                                      0, 1, 0, 15);
    addVec("halt_stl",  mkIn(0, 0, 1, 1, 0, 0, 0,   0,    0),      0, 0, 1, 16);
    addVec("done_hold", mkIn(0, 0, 0, 1, 1, 0, 1,   9,    0),      0, 0, 1, 16);
    addVec("rearm",     mkIn(0, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("rerun",     idle,                                      0, 1, 0, 0);
    addVec("abs_300",   mkIn(0, 0, 0, 0, 1, 0, 1, 300,    0),    300, 1, 0, 1);
    addVec("rst_mid",   mkIn(1, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("post_rst",  idle,                                      0, 0, 0, 0);
    addVec("arm_b",     mkIn(0, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("run_b0",    idle,                                      0, 1, 0, 0);
    addVec("run_b1",    idle,                                      1, 1, 0, 1);
    addVec("restart",   mkIn(0, 1, 0, 0, 0, 0, 0,   0,    0),      0, 0, 0, 0);
    addVec("run_c0",    idle,                                      0, 1, 0, 0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].in);
      checkOutput(vecs[k].name, vecs[k].pc, vecs[k].run, vecs[k].done, vecs[k].cnt);
    end

    // Straight-line run 0..42, halt at 42, then restart clears PC and count.
    for (int n = 1; n <= 42; n++) applyStimulus(idle);
    checkOutput("line_pc42", 42, 1, 0, 42);
    applyStimulus(mkIn(0,0,0,1,0,0,0,0,0));
    checkOutput("line_halt", 42, 0, 1, 43);
    for (int n = 0; n < 3; n++) applyStimulus(idle);
    checkOutput("line_held", 42, 0, 1, 43);
    applyStimulus(mkIn(0,1,0,0,0,0,0,0,0));
    checkOutput("line_rearm", 0, 0, 0, 0);
    applyStimulus(idle);
    checkOutput("line_rerun", 0, 1, 0, 0);

    // Randomized phase against the behavioural model.
    applyStimulus(mkIn(1,0,0,0,0,0,0,0,0));
    checkModel("rand_reset");
    for (int n = 0; n < 3000; n++) begin
      r.rst    = ($urandom_range(0, 199) == 0);
      r.start  = ($urandom_range(0, 39) == 0);
      r.stall  = ($urandom_range(0, 3) == 0);
      r.halt   = ($urandom_range(0, 49) == 0);
      r.babs   = ($urandom_range(0, 5) == 0);
      r.brel   = ($urandom_range(0, 4) == 0);
      r.taken  = $urandom_range(0, 1) == 1;
      r.target = 11'($urandom);
      r.offset = 8'($urandom);
      applyStimulus(r);
      checkModel("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
